// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters and the memory.
// The slave view belongs to the arbiter; the master view belongs to requesters plus memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              p_req;
    logic              p_rw;
    logic [ADDR_W-1:0] p_addr;
    logic [DATA_W-1:0] p_wdata;
    logic              p_gnt;
    logic              p_stall;
    logic [DATA_W-1:0] p_rdata;

    logic              d_req;
    logic              d_rw;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;

    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  p_req, p_rw, p_addr, p_wdata,
        output p_gnt, p_stall, p_rdata,
        input  d_req, d_rw, d_addr, d_wdata,
        output d_ack, d_rdata,
        output m_rw, m_addr, m_wdata,
        input  m_rdata
    );

    modport master (
        output p_req, p_rw, p_addr, p_wdata,
        input  p_gnt, p_stall, p_rdata,
        output d_req, d_rw, d_addr, d_wdata,
        input  d_ack, d_rdata,
        input  m_rw, m_addr, m_wdata,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Single-port data memory arbiter: pipeline port P has priority, DMA port D is
// guaranteed service after STARVE_MAX consecutive lost cycles.
module dmem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic           clk,
    input  logic           reset,
    dmem_arbiter_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        ACK  = 1'b1
    } state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state_q;
    logic [3:0]        starve_q;
    logic [3:0]        starve_d;
    logic              ack_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    logic d_elig;
    logic d_force;
    logic d_win;
    logic p_win;

    // Arbitration is gated by reset so nothing reaches the memory while reset is low.
    always_comb begin
        d_elig  = bus.d_req & (state_q == IDLE) & reset;
        d_force = d_elig & (starve_q == STARVE_LIM);
        p_win   = bus.p_req & reset & ~d_force;
        d_win   = d_elig & (d_force | ~bus.p_req);
    end

    always_comb begin
        bus.m_rw    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        if (p_win) begin
            bus.m_rw    = bus.p_rw;
            bus.m_addr  = bus.p_addr;
            bus.m_wdata = bus.p_wdata;
        end else if (d_win) begin
            bus.m_rw    = bus.d_rw;
            bus.m_addr  = bus.d_addr;
            bus.m_wdata = bus.d_wdata;
        end
    end

    assign bus.p_gnt   = p_win;
    assign bus.p_stall = bus.p_req & ~p_win;
    assign bus.p_rdata = (p_win & ~bus.p_rw) ? bus.m_rdata : '0;
    assign bus.d_ack   = ack_q;
    assign bus.d_rdata = rdata_q;

    // Starvation only accrues while D is actually waiting and P takes the slot.
    always_comb begin
        starve_d = starve_q;
        if (d_win) begin
            starve_d = '0;
        end else if (d_elig && p_win && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + 4'd1;
        end
        rdata_d = (d_win && !bus.d_rw) ? bus.m_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            starve_q <= '0;
            ack_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            starve_q <= starve_d;
            rdata_q  <= rdata_d;
            case (state_q)
                IDLE: begin
                    if (d_win) begin
                        state_q <= ACK;
                        ack_q   <= 1'b1;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural arbitration model.
module tb_dmem_arbiter;
    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic clk;
    logic reset;

    dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: combinational read, write on the rising edge.
    logic [DW-1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) if (bus.m_rw) mem[bus.m_addr[7:0]] <= bus.m_wdata;
    assign bus.m_rdata = mem[bus.m_addr[7:0]];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: "busy acknowledging" flag, consecutive-loss count, memory image.
    logic [DW-1:0] mmem [256];
    initial for (int i = 0; i < 256; i++) mmem[i] = '0;
    bit            m_in_ack = 0;
    int            m_lost   = 0;
    logic          m_ack    = 1'b0;
    logic [DW-1:0] m_rd     = '0;
    int            cyc      = 0;
    bit            prev_dreq = 0;
    bit            waiting   = 0;
    int            start_cyc = 0;
    int            winner;   // 0 none, 1 P, 2 D
    bit            d_ready;
    logic          e_rw;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_prdata;

    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            chk("rst_p_gnt",   bus.p_gnt,   1'b0);
            chk("rst_m_rw",    bus.m_rw,    1'b0);
            chk("rst_d_ack",   bus.d_ack,   1'b0);
            chk("rst_d_rdata", bus.d_rdata, '0);
            m_in_ack = 0; m_lost = 0; m_ack = 1'b0; m_rd = '0;
            waiting = 0;
            prev_dreq = bus.d_req;
        end else begin
            d_ready = bus.d_req && !m_in_ack;
            if (d_ready && (m_lost == SMAX || !bus.p_req)) winner = 2;
            else if (bus.p_req)                              winner = 1;
            else                                             winner = 0;

            e_rw = 1'b0; e_addr = '0; e_wdata = '0; e_prdata = '0;
            if (winner == 1) begin
                e_rw = bus.p_rw; e_addr = bus.p_addr; e_wdata = bus.p_wdata;
                if (!bus.p_rw) e_prdata = mmem[bus.p_addr[7:0]];
            end else if (winner == 2) begin
                e_rw = bus.d_rw; e_addr = bus.d_addr; e_wdata = bus.d_wdata;
            end

            chk("p_gnt",   bus.p_gnt,   winner == 1);
            chk("p_stall", bus.p_stall, bus.p_req && winner != 1);
            chk("p_rdata", bus.p_rdata, e_prdata);
            chk("m_rw",    bus.m_rw,    e_rw);
            chk("m_addr",  bus.m_addr,  e_addr);
            chk("m_wdata", bus.m_wdata, e_wdata);
            chk("d_ack",   bus.d_ack,   m_ack);
            chk("d_rdata", bus.d_rdata, m_rd);

            if (waiting && bus.d_ack) begin
                chk("d_latency_ok", (cyc - start_cyc) <= SMAX + 2, 1'b1);
                waiting = 0;
            end else if (waiting && (cyc - start_cyc) > SMAX + 2) begin
                chk("d_latency_timeout", 1'b0, 1'b1);
                waiting = 0;
            end
            if (bus.d_req && !prev_dreq) begin
                waiting = 1;
                start_cyc = cyc;
            end
            prev_dreq = bus.d_req;

            // State after the coming rising edge.
            if (winner == 2) begin
                if (bus.d_rw) mmem[bus.d_addr[7:0]] = bus.d_wdata;
                else          m_rd = mmem[bus.d_addr[7:0]];
                m_ack = 1'b1; m_in_ack = 1; m_lost = 0;
            end else begin
                m_ack = 1'b0; m_in_ack = 0;
                if (d_ready && winner == 1 && m_lost < SMAX) m_lost++;
                if (winner == 1 && bus.p_rw) mmem[bus.p_addr[7:0]] = bus.p_wdata;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.p_req = 1'b0; bus.p_rw = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        bus.p_req = 1'b1; bus.p_rw = 1'b1; bus.p_addr = 32'h10;
        @(negedge clk);
        chk("lit_rst_gnt", bus.p_gnt, 1'b0);
        chk("lit_rst_mrw", bus.m_rw, 1'b0);
        tick();
        reset = 1'b1;

        // P write then P read of 0x10.
        bus.p_req = 1'b1; bus.p_rw = 1'b1; bus.p_addr = 32'h10; bus.p_wdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("lit_pw_gnt",  bus.p_gnt, 1'b1);
        chk("lit_pw_addr", bus.m_addr, 32'h10);
        tick();
        bus.p_rw = 1'b0; bus.p_wdata = '0;
        @(negedge clk);
        chk("lit_pr_gnt",   bus.p_gnt, 1'b1);
        chk("lit_pr_rdata", bus.p_rdata, 32'hDEADBEEF);
        chk("lit_pr_dack",  bus.d_ack, 1'b0);
        tick();

        // D read of 0x10 with P idle; d_req stays high into the ack cycle.
        idle_inputs();
        bus.d_req = 1'b1; bus.d_addr = 32'h10;
        @(negedge clk);
        chk("lit_dr_addr", bus.m_addr, 32'h10);
        tick();
        @(negedge clk);
        chk("lit_dr_ack",   bus.d_ack, 1'b1);
        chk("lit_dr_rdata", bus.d_rdata, 32'hDEADBEEF);
        chk("lit_dr_noacc", bus.m_addr, 32'h0);
        tick();
        bus.d_req = 1'b0;
        tick();

        // Continuous P traffic against a waiting D.
        bus.p_req = 1'b1; bus.p_rw = 1'b0; bus.p_addr = 32'h10;
        bus.d_req = 1'b1; bus.d_rw = 1'b0; bus.d_addr = 32'h20;
        for (int i = 0; i < SMAX; i++) begin
            @(negedge clk);
            chk("lit_st_pgnt", bus.p_gnt, 1'b1);
            tick();
        end
        @(negedge clk);
        chk("lit_st_dwin_gnt",   bus.p_gnt, 1'b0);
        chk("lit_st_dwin_stall", bus.p_stall, 1'b1);
        chk("lit_st_dwin_addr",  bus.m_addr, 32'h20);
        tick();
        @(negedge clk);
        chk("lit_st_ack",     bus.d_ack, 1'b1);
        chk("lit_st_ack_gnt", bus.p_gnt, 1'b1);
        tick();
        idle_inputs();
        tick();

        // D write followed by P read of the same word during the ack cycle.
        bus.d_req = 1'b1; bus.d_rw = 1'b1; bus.d_addr = 32'h20; bus.d_wdata = 32'h12345678;
        @(negedge clk);
        chk("lit_dw_mrw",   bus.m_rw, 1'b1);
        chk("lit_dw_wdata", bus.m_wdata, 32'h12345678);
        tick();
        idle_inputs();
        bus.p_req = 1'b1; bus.p_addr = 32'h20;
        @(negedge clk);
        chk("lit_dw_readback", bus.p_rdata, 32'h12345678);
        tick();
        idle_inputs();

        // Reset while acknowledging.
        bus.d_req = 1'b1; bus.d_addr = 32'h10;
        tick();
        bus.d_req = 1'b0;
        reset = 1'b0;
        #1;
        chk("lit_ra_ack",   bus.d_ack, 1'b0);
        chk("lit_ra_rdata", bus.d_rdata, '0);
        chk("lit_ra_mrw",   bus.m_rw, 1'b0);
        tick();
        reset = 1'b1;
        bus.p_req = 1'b1; bus.p_rw = 1'b1; bus.p_addr = 32'h30; bus.p_wdata = 32'hA5A5A5A5;
        @(negedge clk);
        chk("lit_ra_first_gnt", bus.p_gnt, 1'b1);
        tick();
        idle_inputs();

        // Ten idle cycles leave memory untouched.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("lit_idle_mrw",  bus.m_rw, 1'b0);
            chk("lit_idle_addr", bus.m_addr, 32'h0);
            tick();
        end
        bus.p_req = 1'b1; bus.p_addr = 32'h10;
        @(negedge clk);
        chk("lit_idle_readback", bus.p_rdata, 32'hDEADBEEF);
        tick();
        idle_inputs();

        // Randomized traffic; every other 100-cycle window saturates P.
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) reset = 1'b0;
            if (c == 1502) reset = 1'b1;
            bus.p_req   = ((c / 100) % 2 == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
            bus.p_rw    = 1'($urandom_range(0, 1));
            bus.p_addr  = 32'($urandom_range(0, 31));
            bus.p_wdata = $urandom;
            if (bus.d_req) begin
                if (bus.d_ack) begin
                    if ($urandom_range(0, 1) == 0) begin
                        bus.d_req = 1'b0;
                    end else begin
                        bus.d_rw    = 1'($urandom_range(0, 1));
                        bus.d_addr  = 32'($urandom_range(0, 31));
                        bus.d_wdata = $urandom;
                    end
                end
            end else if ($urandom_range(0, 3) == 0) begin
                bus.d_req   = 1'b1;
                bus.d_rw    = 1'($urandom_range(0, 1));
                bus.d_addr  = 32'($urandom_range(0, 31));
                bus.d_wdata = $urandom;
            end
            tick();
        end
        idle_inputs();
        repeat (3) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
